// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB GPIO peripheral with per-pin direction, atomic output set/clear, a
// multi-stage input synchroniser and an optional edge/level interrupt unit.
//
// Parameters:
//   WIDTH        number of GPIO pins (1..32)
//   SYNC_STAGES  input synchroniser depth (2..4)
//   ADDR_W       APB address width; registers decode on paddr[5:2], upper bits must be 0
//
// Ports:
//   pclk, presetn            clock, asynchronous active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB address / write data
//   prdata, pready, pslverr  APB read data (0 outside access phase), ready (always 1), error
//   gpio_i                   asynchronous pin inputs
//   gpio_o, gpio_oe          output data and output enable (1 = drive)
//   irq                      level interrupt request
//
// Build option: define APB_GPIO_IRQ_EN to include the interrupt unit (IRQ_EN, IRQ_TYPE,
// IRQ_POL, IRQ_STAT, the previous-sample flop and irq). Without it, offsets 0x14-0x20
// return errors and irq is tied low.
//
// Register map (byte offsets):
//   0x00 OUT RW, 0x04 DIR RW, 0x08 IN RO, 0x0C OUT_SET WO, 0x10 OUT_CLR WO,
//   0x14 IRQ_EN RW, 0x18 IRQ_TYPE RW (1 = edge), 0x1C IRQ_POL RW (1 = rising/high),
//   0x20 IRQ_STAT W1C

module apb_gpio_irq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [3:0] OffOut   = 4'h0;
  localparam logic [3:0] OffDir   = 4'h1;
  localparam logic [3:0] OffIn    = 4'h2;
  localparam logic [3:0] OffSet   = 4'h3;
  localparam logic [3:0] OffClr   = 4'h4;
`ifdef APB_GPIO_IRQ_EN
  localparam logic [3:0] OffEn    = 4'h5;
  localparam logic [3:0] OffType  = 4'h6;
  localparam logic [3:0] OffPol   = 4'h7;
  localparam logic [3:0] OffStat  = 4'h8;
`endif

  logic             access;
  logic             addr_err;
  logic             dec_err;
  logic             wr_en;
  logic [31:0]      rd_data;
  logic [WIDTH-1:0] wdata;
  logic             sel_out;
  logic             sel_dir;
  logic             sel_set;
  logic             sel_clr;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic             unused_bits;

`ifdef APB_GPIO_IRQ_EN
  logic             sel_en;
  logic             sel_type;
  logic             sel_pol;
  logic             sel_stat;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_type_q;
  logic [WIDTH-1:0] irq_pol_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] irq_stat_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_set;
  logic [WIDTH-1:0] w1c;
`endif

  assign access      = psel & penable;
  assign wdata       = pwdata[WIDTH-1:0];
  assign pready      = 1'b1;
  // Byte-lane bits and pwdata bits above WIDTH carry no meaning.
  assign unused_bits = ^{paddr[1:0], pwdata};

  if (ADDR_W > 6) begin : g_upper
    assign addr_err = |paddr[ADDR_W-1:6];
  end else begin : g_no_upper
    assign addr_err = 1'b0;
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Address decode, read mux and error detection.
  always_comb begin
    dec_err  = 1'b0;
    rd_data  = '0;
    sel_out  = 1'b0;
    sel_dir  = 1'b0;
    sel_set  = 1'b0;
    sel_clr  = 1'b0;
`ifdef APB_GPIO_IRQ_EN
    sel_en   = 1'b0;
    sel_type = 1'b0;
    sel_pol  = 1'b0;
    sel_stat = 1'b0;
`endif
    case (paddr[5:2])
      OffOut: begin
        rd_data = 32'(out_q);
        sel_out = 1'b1;
      end
      OffDir: begin
        rd_data = 32'(dir_q);
        sel_dir = 1'b1;
      end
      OffIn: begin
        rd_data = 32'(s);
        dec_err = pwrite;
      end
      OffSet:  sel_set = 1'b1;
      OffClr:  sel_clr = 1'b1;
`ifdef APB_GPIO_IRQ_EN
      OffEn: begin
        rd_data = 32'(irq_en_q);
        sel_en  = 1'b1;
      end
      OffType: begin
        rd_data  = 32'(irq_type_q);
        sel_type = 1'b1;
      end
      OffPol: begin
        rd_data = 32'(irq_pol_q);
        sel_pol = 1'b1;
      end
      OffStat: begin
        rd_data  = 32'(irq_stat_q);
        sel_stat = 1'b1;
      end
`endif
      default: dec_err = 1'b1;
    endcase
    if (addr_err) begin
      dec_err = 1'b1;
    end
  end

  // Erroring accesses never commit and always read back zero.
  assign wr_en   = access & pwrite & ~dec_err;
  assign pslverr = access & dec_err;
  assign prdata  = (access & ~dec_err) ? rd_data : '0;

  always_comb begin
    out_d = out_q;
    if (wr_en) begin
      if (sel_out) begin
        out_d = wdata;
      end else if (sel_set) begin
        out_d = out_q | wdata;
      end else if (sel_clr) begin
        out_d = out_q & ~wdata;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      if (wr_en && sel_dir) begin
        dir_q <= wdata;
      end
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef APB_GPIO_IRQ_EN
  // Edge detection compares the synchronised value against its previous sample.
  always_comb begin
    irq_set = (irq_type_q & ((irq_pol_q & s & ~prev_q) | (~irq_pol_q & ~s & prev_q)))
            | (~irq_type_q & ~(s ^ irq_pol_q));
    w1c        = (wr_en && sel_stat) ? wdata : '0;
    // A set in the same cycle as a W1C wins.
    irq_stat_d = (irq_stat_q & ~w1c) | irq_set;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_en_q   <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
    end else begin
      prev_q     <= s;
      irq_stat_q <= irq_stat_d;
      if (wr_en && sel_en) begin
        irq_en_q <= wdata;
      end
      if (wr_en && sel_type) begin
        irq_type_q <= wdata;
      end
      if (wr_en && sel_pol) begin
        irq_pol_q <= wdata;
      end
    end
  end

  assign irq = |(irq_stat_q & irq_en_q);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_gpio_irq.sv
`timescale 1ns/1ps
module tb_apb_gpio_irq;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ADDR_W      = 12;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [WIDTH-1:0]  gpio_i = '0;
  logic [WIDTH-1:0]  gpio_o;
  logic [WIDTH-1:0]  gpio_oe;
  logic              irq;

  apb_gpio_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq    (irq)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the commit edge, so calls chain
  // back-to-back with no idle cycle.
  task automatic apb(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output logic err);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    rdata = prdata;
    err   = pslverr;
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, addr, data, rd, err);
    check(name, 32'(err), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, addr, 32'd0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rd;
    logic              exp_err;
    logic [31:0]       exp_o;
    logic [31:0]       exp_oe;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic err, input logic [31:0] o,
                         input logic [31:0] oe);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd; v.exp_rd = rd;
    v.exp_err = err; v.exp_o = o; v.exp_oe = oe;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        irq_build;
    logic [31:0] m_out;
    logic [31:0] m_dir;
    logic [31:0] m_in;

`ifdef APB_GPIO_IRQ_EN
    irq_build = 1'b1;
`else
    irq_build = 1'b0;
`endif

    // Reset state, checked while presetn is held low.
    #3;
    check("reset gpio_o", 32'(gpio_o), 32'd0);
    check("reset gpio_oe", 32'(gpio_oe), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset pready", 32'(pready), 32'd1);
    check("reset prdata", prdata, 32'd0);
    check("reset pslverr", 32'(pslverr), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    cycles(1);

    // Read every register after reset. With pins low, the reset IRQ configuration is
    // level-low on every pin, so IRQ_STAT fills with ones immediately after reset.
    for (int off = 0; off <= 8; off++) begin
      apb(1'b0, ADDR_W'(off * 4), 32'd0, rd, err);
      if (off >= 5 && !irq_build) begin
        check($sformatf("reset rd err @%0h", off * 4), 32'(err), 32'd1);
        check($sformatf("reset rd @%0h", off * 4), rd, 32'd0);
      end else begin
        check($sformatf("reset rd err @%0h", off * 4), 32'(err), 32'd0);
        check($sformatf("reset rd @%0h", off * 4), rd,
              (off == 8) ? 32'hFFFF_FFFF : 32'd0);
      end
    end

    // Reset asserted during the access phase of a write: the write must not land.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = '0; pwdata = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("midwrite reset gpio_o", 32'(gpio_o), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    cycles(1);
    rd_chk("midwrite reset OUT", 12'h000, 32'd0);

    // Register access table.
    add_vec(1'b1, 12'h000, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_00F0, 32'h0);
    add_vec(1'b1, 12'h00C, 32'h0000_000F, 32'h0, 1'b0, 32'h0000_00FF, 32'h0);
    add_vec(1'b1, 12'h010, 32'h0000_0030, 32'h0, 1'b0, 32'h0000_00CF, 32'h0);
    add_vec(1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, 32'h0000_00CF, 32'h0);
    add_vec(1'b0, 12'h010, 32'h0, 32'h0, 1'b0, 32'h0000_00CF, 32'h0);
    add_vec(1'b0, 12'h000, 32'h0, 32'h0000_00CF, 1'b0, 32'h0000_00CF, 32'h0);
    add_vec(1'b1, 12'h004, 32'h0000_FFFF, 32'h0, 1'b0, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b0, 12'h004, 32'h0, 32'h0000_FFFF, 1'b0, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b0, 12'h024, 32'h0, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h008, 32'h0000_0123, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b0, 12'h040, 32'h0, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h040, 32'h0, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h03C, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h810, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h844, 32'h0, 32'h0, 1'b1, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b0, 12'h014, 32'h0, 32'h0, !irq_build, 32'h0000_00CF, 32'h0000_FFFF);
    add_vec(1'b1, 12'h018, 32'hFFFF_FFFF, 32'h0, !irq_build, 32'h0000_00CF, 32'h0000_FFFF);

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      check($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d gpio_o", i), 32'(gpio_o), vecs[i].exp_o);
      check($sformatf("vec%0d gpio_oe", i), 32'(gpio_oe), vecs[i].exp_oe);
    end

    // Synchroniser latency: a change stable before edge k is not visible between k and
    // k+1, and is visible from k+1 on.
    gpio_i = 32'h0000_00A5;
    apb(1'b0, 12'h008, 32'd0, rd, err);
    check("sync early IN", rd, 32'd0);
    gpio_i = 32'h0000_005A;
    cycles(1);
    apb(1'b0, 12'h008, 32'd0, rd, err);
    check("sync on-time IN", rd, 32'h0000_005A);

    // Randomised GPIO traffic against a register-level model.
    m_out = 32'd0;
    m_dir = 32'd0;
    wr_chk("rand init OUT", 12'h000, 32'd0);
    wr_chk("rand init DIR", 12'h004, 32'd0);
    for (int it = 0; it < 150; it++) begin
      int          op;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        is_rd;
      logic [ADDR_W-1:0] addr;
      m_in   = $urandom;
      gpio_i = m_in;
      cycles(2);
      op      = int'($urandom_range(0, 7));
      data    = $urandom;
      exp_rd  = 32'd0;
      exp_err = 1'b0;
      is_rd   = 1'b0;
      addr    = '0;
      case (op)
        0: begin addr = 12'h000; m_out = data; end
        1: begin addr = 12'h004; m_dir = data; end
        2: begin addr = 12'h00C; m_out = m_out | data; end
        3: begin addr = 12'h010; m_out = m_out & ~data; end
        4: begin addr = 12'h000; is_rd = 1'b1; exp_rd = m_out; end
        5: begin addr = 12'h004; is_rd = 1'b1; exp_rd = m_dir; end
        6: begin addr = 12'h008; is_rd = 1'b1; exp_rd = m_in; end
        default: begin
          exp_err = 1'b1;
          case ($urandom_range(0, 2))
            0: addr = 12'h008;
            1: begin addr = ADDR_W'(12'h024 + 4 * $urandom_range(0, 6)); is_rd = 1'b1; end
            default: addr = ADDR_W'(12'h040 << $urandom_range(0, 5));
          endcase
        end
      endcase
      apb(!is_rd, addr, data, rd, err);
      check($sformatf("rand%0d pslverr", it), 32'(err), 32'(exp_err));
      if (is_rd) begin
        check($sformatf("rand%0d prdata", it), rd, exp_rd);
      end
      check($sformatf("rand%0d gpio_o", it), 32'(gpio_o), m_out);
      check($sformatf("rand%0d gpio_oe", it), 32'(gpio_oe), m_dir);
      if (!irq_build) begin
        check($sformatf("rand%0d irq", it), 32'(irq), 32'd0);
      end
    end

`ifdef APB_GPIO_IRQ_EN
    // Rising-edge interrupt on pin 3.
    gpio_i = '0;
    cycles(3);
    wr_chk("irq cfg TYPE", 12'h018, 32'hFFFF_FFFF);
    wr_chk("irq cfg POL", 12'h01C, 32'h0000_0008);
    wr_chk("irq cfg EN", 12'h014, 32'h0000_0008);
    wr_chk("irq clr all", 12'h020, 32'hFFFF_FFFF);
    rd_chk("irq stat clear", 12'h020, 32'd0);
    check("irq idle", 32'(irq), 32'd0);
    gpio_i = 32'h0000_0008;
    cycles(1);
    gpio_i = '0;
    cycles(3);
    check("irq edge raised", 32'(irq), 32'd1);
    rd_chk("irq edge stat", 12'h020, 32'h0000_0008);
    wr_chk("irq edge w1c", 12'h020, 32'h0000_0008);
    check("irq after w1c", 32'(irq), 32'd0);
    rd_chk("irq stat after w1c", 12'h020, 32'd0);

    // Edge event landing on the same cycle as the W1C: set wins.
    gpio_i = 32'h0000_0008;
    cycles(1);
    gpio_i = '0;
    wr_chk("irq collide w1c", 12'h020, 32'h0000_0008);
    check("irq collide irq", 32'(irq), 32'd1);
    rd_chk("irq collide stat", 12'h020, 32'h0000_0008);
    wr_chk("irq collide clr", 12'h020, 32'h0000_0008);

    // Level-low on pin 0: a W1C while the level persists is immediately overridden.
    wr_chk("lvl TYPE", 12'h018, 32'hFFFF_FFFE);
    wr_chk("lvl POL", 12'h01C, 32'h0000_0000);
    wr_chk("lvl EN", 12'h014, 32'h0000_0001);
    cycles(2);
    wr_chk("lvl w1c", 12'h020, 32'hFFFF_FFFF);
    check("lvl irq persists", 32'(irq), 32'd1);
    rd_chk("lvl stat persists", 12'h020, 32'h0000_0001);
    gpio_i = 32'h0000_0001;
    cycles(3);
    wr_chk("lvl w1c released", 12'h020, 32'h0000_0001);
    rd_chk("lvl stat released", 12'h020, 32'd0);
    check("lvl irq released", 32'(irq), 32'd0);

    // Status sets even when masked; only irq is gated by IRQ_EN.
    wr_chk("mask EN off", 12'h014, 32'd0);
    gpio_i = '0;
    cycles(3);
    rd_chk("mask stat sets", 12'h020, 32'h0000_0001);
    check("mask irq low", 32'(irq), 32'd0);
`else
    check("no-irq build irq", 32'(irq), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
